// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables and flushes, PC enable,
// the halt-drain state machine and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned FCNT_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dren_mem,
    input  logic              dwen_mem,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic [REG_W-1:0]  dc_rs,
    input  logic [REG_W-1:0]  dc_rt,
    input  logic              dc_uses_rt,
    input  logic              redirect_mem,
    input  logic              halt_mem,
    output logic              pc_en,
    output logic              ifdc_en,
    output logic              dcex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifdc_flush,
    output logic              dcex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              halt_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [FCNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                halt_q, halt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic luse;
    logic stall_inc;
    logic flush_inc;

    assign mem_busy = (dren_mem | dwen_mem) & ~dhit;

    // Register 0 is hardwired, so a load targeting it never creates a real dependency.
    assign luse = ex_memread & (ex_rt != '0) &
                  ((ex_rt == dc_rs) | (dc_uses_rt & (ex_rt == dc_rt)));

    always_comb begin
        pc_en       = 1'b0;
        ifdc_en     = 1'b0;
        dcex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifdc_flush  = 1'b0;
        dcex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;

        if (nRST) begin
            unique case (state_q)
                StRun: begin
                    if (mem_busy) begin
                        // WB gets a bubble so the stalled MEM result is not written twice.
                        memwb_en    = 1'b1;
                        memwb_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (halt_mem) begin
                        ifdc_en     = 1'b1;
                        dcex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifdc_flush  = 1'b1;
                        dcex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        state_d     = StDrain;
                    end else if (redirect_mem) begin
                        pc_en       = 1'b1;
                        ifdc_en     = 1'b1;
                        dcex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifdc_flush  = 1'b1;
                        dcex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (luse) begin
                        dcex_en     = 1'b1;
                        dcex_flush  = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (!ihit) begin
                        ifdc_en     = 1'b1;
                        ifdc_flush  = 1'b1;
                        dcex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        stall_inc   = 1'b1;
                    end else begin
                        pc_en       = 1'b1;
                        ifdc_en     = 1'b1;
                        dcex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                    end
                end
                StDrain: begin
                    memwb_en    = 1'b1;
                    memwb_flush = 1'b1;
                    state_d     = StHalted;
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_comb begin
        halt_d      = halt_q | (state_q == StDrain);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StRun;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halt_out  = halt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle model pushes expected controls and counters,
// which are popped and compared mid-cycle. A second instance uses a 4-bit stall counter.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST = 1'b1;
    logic       ihit = 1'b0, dhit = 1'b0, dren_mem = 1'b0, dwen_mem = 1'b0;
    logic       ex_memread = 1'b0, dc_uses_rt = 1'b0, redirect_mem = 1'b0, halt_mem = 1'b0;
    logic [4:0] ex_rt = '0, dc_rs = '0, dc_rt = '0;

    logic        pc_en, ifdc_en, dcex_en, exmem_en, memwb_en;
    logic        ifdc_flush, dcex_flush, exmem_flush, memwb_flush, halt_out;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        pc_en4, ifdc_en4, dcex_en4, exmem_en4, memwb_en4;
    logic        ifdc_flush4, dcex_flush4, exmem_flush4, memwb_flush4, halt_out4;
    logic [3:0]  stall_cnt4;
    logic [15:0] flush_cnt4;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dren_mem(dren_mem),
        .dwen_mem(dwen_mem), .ex_memread(ex_memread), .ex_rt(ex_rt), .dc_rs(dc_rs),
        .dc_rt(dc_rt), .dc_uses_rt(dc_uses_rt), .redirect_mem(redirect_mem),
        .halt_mem(halt_mem), .pc_en(pc_en), .ifdc_en(ifdc_en), .dcex_en(dcex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifdc_flush(ifdc_flush),
        .dcex_flush(dcex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt_out(halt_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dren_mem(dren_mem),
        .dwen_mem(dwen_mem), .ex_memread(ex_memread), .ex_rt(ex_rt), .dc_rs(dc_rs),
        .dc_rt(dc_rt), .dc_uses_rt(dc_uses_rt), .redirect_mem(redirect_mem),
        .halt_mem(halt_mem), .pc_en(pc_en4), .ifdc_en(ifdc_en4), .dcex_en(dcex_en4),
        .exmem_en(exmem_en4), .memwb_en(memwb_en4), .ifdc_flush(ifdc_flush4),
        .dcex_flush(dcex_flush4), .exmem_flush(exmem_flush4), .memwb_flush(memwb_flush4),
        .halt_out(halt_out4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        string       tag;
        logic [8:0]  ctl;   // {pc, ifdc, dcex, exmem, memwb enables, 4 flushes}
        logic        halt;
        logic [31:0] sc;
        logic [15:0] fc;
        logic [3:0]  sc4;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 run, 1 drain, 2 halted
    int          m_state = 0;
    logic        m_halt  = 1'b0;
    logic [31:0] m_sc    = '0;
    logic [15:0] m_fc    = '0;
    logic [3:0]  m_sc4   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_busy();
        return (dren_mem | dwen_mem) & ~dhit;
    endfunction

    function automatic logic m_luse();
        return ex_memread && ex_rt != 5'd0 &&
               (ex_rt == dc_rs || (dc_uses_rt && ex_rt == dc_rt));
    endfunction

    function automatic logic [8:0] m_ctl();
        if (!nRST) return 9'b0;
        if (m_state == 1) return {5'b00001, 4'b0001};
        if (m_state == 2) return 9'b0;
        if (m_busy())     return {5'b00001, 4'b0001};
        if (halt_mem)     return {5'b01111, 4'b1110};
        if (redirect_mem) return {5'b11111, 4'b1110};
        if (m_luse())     return {5'b00111, 4'b0100};
        if (!ihit)        return {5'b01111, 4'b1000};
        return {5'b11111, 4'b0000};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_halt  = 1'b0;
        m_sc    = '0;
        m_fc    = '0;
        m_sc4   = '0;
    endtask

    task automatic model_step();
        logic stall;
        stall = 1'b0;
        if (m_state == 1) begin
            m_state = 2;
            m_halt  = 1'b1;
        end else if (m_state == 0) begin
            if (m_busy()) stall = 1'b1;
            else if (halt_mem) m_state = 1;
            else if (redirect_mem) begin
                if (m_fc != 16'hffff) m_fc = m_fc + 16'd1;
            end else if (m_luse() || !ihit) stall = 1'b1;
        end
        if (stall) begin
            if (m_sc != 32'hffff_ffff) m_sc = m_sc + 32'd1;
            if (m_sc4 != 4'hf) m_sc4 = m_sc4 + 4'd1;
        end
    endtask

    // Inputs are set just after a rising edge; outputs are compared at the falling edge.
    task automatic cycle(input string tag);
        exp_t e;
        exp_t o;
        if (!nRST) model_reset();
        e.tag  = tag;
        e.ctl  = m_ctl();
        e.halt = m_halt;
        e.sc   = m_sc;
        e.fc   = m_fc;
        e.sc4  = m_sc4;
        exp_q.push_back(e);
        @(negedge CLK);
        o = exp_q.pop_front();
        check_eq({o.tag, ".ctl"}, {23'b0, pc_en, ifdc_en, dcex_en, exmem_en, memwb_en,
                 ifdc_flush, dcex_flush, exmem_flush, memwb_flush}, {23'b0, o.ctl});
        check_eq({o.tag, ".halt"}, {31'b0, halt_out}, {31'b0, o.halt});
        check_eq({o.tag, ".stall_cnt"}, stall_cnt, o.sc);
        check_eq({o.tag, ".flush_cnt"}, {16'b0, flush_cnt}, {16'b0, o.fc});
        check_eq({o.tag, ".stall_cnt4"}, {28'b0, stall_cnt4}, {28'b0, o.sc4});
        @(posedge CLK);
        if (nRST) model_step();
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 1'b1; dhit = 1'b0; dren_mem = 1'b0; dwen_mem = 1'b0;
        ex_memread = 1'b0; dc_uses_rt = 1'b0; redirect_mem = 1'b0; halt_mem = 1'b0;
        ex_rt = '0; dc_rs = '0; dc_rt = '0;
    endtask

    initial begin
        #1 nRST = 1'b0;
        clear_inputs();
        cycle("reset0");
        cycle("reset1");
        nRST = 1'b1;
        cycle("normal0");
        cycle("normal1");

        ex_memread = 1'b1; ex_rt = 5'd8; dc_rs = 5'd8;
        cycle("luse_rs");
        clear_inputs();
        cycle("after_luse");
        ex_memread = 1'b1; ex_rt = 5'd0; dc_rs = 5'd0;
        cycle("luse_r0");
        ex_rt = 5'd5; dc_rs = 5'd3; dc_rt = 5'd5; dc_uses_rt = 1'b1;
        cycle("luse_rt");
        dc_uses_rt = 1'b0;
        cycle("no_luse_rt");
        clear_inputs();

        ihit = 1'b0;
        for (int i = 0; i < 3; i++) cycle("imiss");
        ihit = 1'b1;
        cycle("imiss_done");

        dren_mem = 1'b1; dhit = 1'b0; redirect_mem = 1'b1;
        ex_memread = 1'b1; ex_rt = 5'd4; dc_rs = 5'd4;
        for (int i = 0; i < 4; i++) cycle("dbusy");
        dhit = 1'b1;
        cycle("dhit_redirect");
        clear_inputs();
        dwen_mem = 1'b1;
        cycle("st_busy");
        clear_inputs();
        redirect_mem = 1'b1; ihit = 1'b0;
        cycle("redir_over_imiss");
        clear_inputs();
        cycle("normal2");

        ihit = 1'b0;
        for (int i = 0; i < 20; i++) cycle("sat4");
        clear_inputs();

        halt_mem = 1'b1; redirect_mem = 1'b1;
        cycle("halt");
        clear_inputs();
        cycle("drain");
        ihit = 1'b0; dren_mem = 1'b1; redirect_mem = 1'b1;
        for (int i = 0; i < 12; i++) cycle("halted");
        clear_inputs();

        nRST = 1'b0;
        cycle("rst_pulse");
        nRST = 1'b1;
        cycle("post_rst0");
        cycle("post_rst1");

        halt_mem = 1'b1;
        cycle("halt2");
        clear_inputs();
        nRST = 1'b0;
        cycle("rst_in_drain");
        nRST = 1'b1;
        cycle("post_rst2");
        ihit = 1'b0;
        cycle("post_rst_imiss");
        clear_inputs();
        cycle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
